// File: rtl/sar_result_deser_pkg.sv
// Shared constants for the SAR result deserializer and its word FIFO.
// The word width follows the SAR logic: define SAR_BIT_ADC to override it
// for both blocks at once.
`ifndef SAR_BIT_ADC
`define SAR_BIT_ADC 8
`endif

package sar_result_deser_pkg;

  localparam int BIT_ADC_DEF = `SAR_BIT_ADC;

  // Buffered conversion words; must be a power of two and at least 2.
  localparam int FIFO_DEPTH_DEF = 4;

  // Pointer width for a FIFO of the given depth (log2, at least 1 bit).
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int FIFO_PTR_W_DEF = ptr_width(FIFO_DEPTH_DEF);

  // Width of the optional saturating dropped-word counter.
  localparam int OVR_COUNT_W = 8;

endpackage

// File: rtl/sar_word_fifo.sv
// Synchronous word FIFO for completed conversions.
// Pushes while full are refused unless a pop happens in the same cycle.
// The head word is presented combinationally and reads as 0 when empty.
module sar_word_fifo
  import sar_result_deser_pkg::*;
#(
  parameter int WIDTH = BIT_ADC_DEF,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic             i_clk,
  input  logic             i_xrst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_empty,
  output logic             o_full
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_pop_ok;
  logic w_push_ok;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_W'(DEPTH));
  // A pop only happens when there is something to pop; a full FIFO still
  // accepts a push when the head leaves in the same cycle.
  assign w_pop_ok  = i_pop & ~o_empty;
  assign w_push_ok = i_push & (~o_full | w_pop_ok);

  assign o_rdata   = o_empty ? '0 : r_mem[r_rd_ptr];

  // Storage write.
  // NOTE: the storage array has no reset; occupancy is tracked by the
  // pointers and count, and the output mux hides stale entries.
  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power of two).
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (!i_xrst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sar_result_deser.sv
// SAR result deserializer: captures serial MSB-first bit decisions on each
// falling edge of COMP_CLK, assembles BIT_ADC-bit words, buffers them in a
// small FIFO and hands them out over a valid/ready handshake.
// Optional feature: define SAR_DESER_OVR_COUNT_EN to add OVR_COUNT, a
// saturating count of words dropped because the FIFO was full.
module sar_result_deser
  import sar_result_deser_pkg::*;
#(
  parameter int BIT_ADC    = BIT_ADC_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic               CLK,
  input  logic               XRST,
  input  logic               DIGITAL_OUT,
  input  logic               COMP_CLK,
  input  logic               SYNC,
  output logic [BIT_ADC-1:0] DATA_OUT,
  output logic               DATA_VALID,
  input  logic               DATA_READY,
  output logic               OVERRUN,
  input  logic               OVR_CLR
`ifdef SAR_DESER_OVR_COUNT_EN
  ,
  output logic [OVR_COUNT_W-1:0] OVR_COUNT
`endif
);

  localparam int BCNT_W = (BIT_ADC > 1) ? $clog2(BIT_ADC) : 1;

  // Front-end state: the bit counter doubles as the ALIGN/COLLECT state.
  logic              r_comp_clk_q;
  logic [BCNT_W-1:0] r_bit_cnt;
  logic [BIT_ADC-2:0] r_shift;
  logic              r_overrun;

  logic               w_bit_stb;
  logic               w_capture;
  logic               w_last_bit;
  logic               w_push;
  logic               w_pop;
  logic               w_drop;
  logic [BIT_ADC-1:0] w_word;
  logic               w_fifo_empty;
  logic               w_fifo_full;

  // DIGITAL_OUT is stable at the falling edge of COMP_CLK.
  assign w_bit_stb  = r_comp_clk_q & ~COMP_CLK;
  // SYNC takes priority: a strobe in the same cycle is discarded.
  assign w_capture  = w_bit_stb & ~SYNC;
  assign w_last_bit = (r_bit_cnt == BCNT_W'(BIT_ADC - 1));
  assign w_word     = {r_shift, DIGITAL_OUT};
  assign w_push     = w_capture & w_last_bit;

  assign DATA_VALID = ~w_fifo_empty;
  assign w_pop      = DATA_VALID & DATA_READY;
  // A completed word is lost only if the FIFO is full and nothing leaves.
  assign w_drop     = w_push & w_fifo_full & ~w_pop;
  assign OVERRUN    = r_overrun;

  // Bit capture: edge detect, shift in MSB first, wrap after the last bit.
  always_ff @(posedge CLK) begin
    if (!XRST) begin
      r_comp_clk_q <= 1'b0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
    end else begin
      r_comp_clk_q <= COMP_CLK;
      if (SYNC) begin
        r_bit_cnt <= '0;
        r_shift   <= '0;
      end else if (w_bit_stb) begin
        r_shift   <= w_word[BIT_ADC-2:0];
        r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + 1'b1;
      end
    end
  end

  // Sticky overrun flag; a new drop wins over a same-cycle clear.
  always_ff @(posedge CLK) begin
    if (!XRST) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (OVR_CLR) begin
      r_overrun <= 1'b0;
    end
  end

`ifdef SAR_DESER_OVR_COUNT_EN
  logic [OVR_COUNT_W-1:0] r_ovr_count;

  assign OVR_COUNT = r_ovr_count;

  // Saturating dropped-word count; a drop alongside a clear restarts at 1.
  always_ff @(posedge CLK) begin
    if (!XRST) begin
      r_ovr_count <= '0;
    end else if (OVR_CLR) begin
      r_ovr_count <= w_drop ? OVR_COUNT_W'(1) : '0;
    end else if (w_drop && (r_ovr_count != '1)) begin
      r_ovr_count <= r_ovr_count + 1'b1;
    end
  end
`endif

  sar_word_fifo #(
    .WIDTH (BIT_ADC),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (CLK),
    .i_xrst  (XRST),
    .i_push  (w_push),
    .i_wdata (w_word),
    .i_pop   (w_pop),
    .o_rdata (DATA_OUT),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

endmodule

// File: tb/tb_sar_result_deser.sv
// Self-checking bench for sar_result_deser: directed scenarios plus a
// randomized phase, compared every cycle against a queue-based model.
module tb_sar_result_deser;

  localparam int W     = 8;
  localparam int DEPTH = 4;

  logic         CLK;
  logic         XRST;
  logic         DIGITAL_OUT;
  logic         COMP_CLK;
  logic         SYNC;
  logic [W-1:0] DATA_OUT;
  logic         DATA_VALID;
  logic         DATA_READY;
  logic         OVERRUN;
  logic         OVR_CLR;
`ifdef SAR_DESER_OVR_COUNT_EN
  logic [7:0]   OVR_COUNT;
`endif

  sar_result_deser dut (
    .CLK         (CLK),
    .XRST        (XRST),
    .DIGITAL_OUT (DIGITAL_OUT),
    .COMP_CLK    (COMP_CLK),
    .SYNC        (SYNC),
    .DATA_OUT    (DATA_OUT),
    .DATA_VALID  (DATA_VALID),
    .DATA_READY  (DATA_READY),
    .OVERRUN     (OVERRUN),
    .OVR_CLR     (OVR_CLR)
`ifdef SAR_DESER_OVR_COUNT_EN
    ,
    .OVR_COUNT   (OVR_COUNT)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Reference model: collected bits as a number, output words as a queue.
  logic [W-1:0] m_q[$];
  int           m_nbits;
  int           m_acc;
  bit           m_prev_comp;
  bit           m_ovr;
  int           m_ovr_cnt;
  bit           rnd_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of the model, using the inputs about to be sampled.
  task automatic model_step();
    bit           stb;
    bit           pop;
    bit           push;
    bit           drop;
    logic [W-1:0] word;
    if (!XRST) begin
      m_q.delete();
      m_nbits = 0; m_acc = 0; m_prev_comp = 0; m_ovr = 0; m_ovr_cnt = 0;
      return;
    end
    stb  = m_prev_comp && !COMP_CLK;
    m_prev_comp = COMP_CLK;
    pop  = (m_q.size() > 0) && DATA_READY;
    push = 0;
    word = '0;
    if (SYNC) begin
      m_nbits = 0; m_acc = 0;
    end else if (stb) begin
      m_acc = m_acc * 2 + int'(DIGITAL_OUT);
      m_nbits++;
      if (m_nbits == W) begin
        push = 1; word = W'(m_acc); m_nbits = 0; m_acc = 0;
      end
    end
    drop = push && (m_q.size() == DEPTH) && !pop;
    if (pop) void'(m_q.pop_front());
    if (push && !drop) m_q.push_back(word);
    if (drop) m_ovr = 1;
    else if (OVR_CLR) m_ovr = 0;
    if (OVR_CLR) m_ovr_cnt = drop ? 1 : 0;
    else if (drop && m_ovr_cnt < 255) m_ovr_cnt++;
  endtask

  // Advance one clock and compare every observable output with the model.
  task automatic cycle();
    if (rnd_ready) DATA_READY = 1'(($urandom & 32'h1));
    model_step();
    @(posedge CLK);
    #1;
    chk("valid", 32'(DATA_VALID), 32'(m_q.size() > 0));
    chk("data", 32'(DATA_OUT), (m_q.size() > 0) ? 32'(m_q[0]) : 32'h0);
    chk("overrun", 32'(OVERRUN), 32'(m_ovr));
`ifdef SAR_DESER_OVR_COUNT_EN
    chk("ovr_count", 32'(OVR_COUNT), 32'(m_ovr_cnt));
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // One SAR bit slot up to and including the strobe cycle (4 of 6 cycles).
  task automatic send_bit(input bit b, input bit sync_on_stb);
    COMP_CLK = 1'b1;
    DIGITAL_OUT = b;
    idle(3);
    COMP_CLK = 1'b0;
    SYNC = sync_on_stb;
    cycle();
    SYNC = 1'b0;
  endtask

  // Full word MSB first; tail=0 stops right after the last strobe cycle.
  task automatic send_word(input logic [W-1:0] w, input bit tail);
    for (int i = W - 1; i >= 0; i--) begin
      send_bit(w[i], 1'b0);
      if (i != 0 || tail) idle(2);
    end
  endtask

  task automatic drain();
    DATA_READY = 1'b1;
    idle(DEPTH + 2);
    chk("drained", 32'(DATA_VALID), 32'h0);
  endtask

  initial begin
    logic [W-1:0] v;
    XRST = 1'b0; DIGITAL_OUT = 1'b0; COMP_CLK = 1'b0; SYNC = 1'b0;
    DATA_READY = 1'b0; OVR_CLR = 1'b0; rnd_ready = 1'b0;

    // Reset state
    idle(2);
    chk("rst_valid", 32'(DATA_VALID), 32'h0);
    chk("rst_data", 32'(DATA_OUT), 32'h0);
    chk("rst_overrun", 32'(OVERRUN), 32'h0);
    XRST = 1'b1;
    idle(2);

    // 1,0,1,1,0,0,1,0 -> B2, valid for exactly one cycle with READY high
    DATA_READY = 1'b1;
    send_word(8'hB2, 1'b0);
    chk("b2_valid", 32'(DATA_VALID), 32'h1);
    chk("b2_data", 32'(DATA_OUT), 32'hB2);
    idle(1);
    chk("b2_valid_fall", 32'(DATA_VALID), 32'h0);
    idle(1);

    // Three words held, then drained in order
    DATA_READY = 1'b0;
    send_word(8'h00, 1'b1);
    send_word(8'hFF, 1'b1);
    send_word(8'h5A, 1'b1);
    chk("hold_valid", 32'(DATA_VALID), 32'h1);
    DATA_READY = 1'b1;
    chk("drain0", 32'(DATA_OUT), 32'h00);
    idle(1);
    chk("drain1", 32'(DATA_OUT), 32'hFF);
    idle(1);
    chk("drain2", 32'(DATA_OUT), 32'h5A);
    idle(1);
    chk("drain_empty", 32'(DATA_VALID), 32'h0);

    // Overrun: five words into a four-deep FIFO
    DATA_READY = 1'b0;
    for (int i = 1; i <= 5; i++) send_word(W'(i), 1'b1);
    chk("ovr_set", 32'(OVERRUN), 32'h1);
    chk("ovr_head", 32'(DATA_OUT), 32'h01);
`ifdef SAR_DESER_OVR_COUNT_EN
    chk("ovr_cnt1", 32'(OVR_COUNT), 32'h1);
`endif
    OVR_CLR = 1'b1;
    idle(1);
    OVR_CLR = 1'b0;
    chk("ovr_clr", 32'(OVERRUN), 32'h0);
    DATA_READY = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("ovr_order", 32'(DATA_OUT), 32'(i));
      idle(1);
    end
    chk("ovr_empty", 32'(DATA_VALID), 32'h0);

    // SYNC after 3 bits, then C3
    DATA_READY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send_bit(1'b1, 1'b0);
      idle(2);
    end
    SYNC = 1'b1;
    idle(1);
    SYNC = 1'b0;
    send_word(8'hC3, 1'b1);
    chk("sync_word", 32'(DATA_OUT), 32'hC3);
    DATA_READY = 1'b1;
    idle(1);
    chk("sync_single", 32'(DATA_VALID), 32'h0);

    // SYNC on the 5th strobe discards that bit and the partial word
    DATA_READY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send_bit(1'b1, (i == 4));
      idle(2);
    end
    chk("sync_stb_none", 32'(DATA_VALID), 32'h0);
    send_word(8'h3C, 1'b1);
    chk("sync_stb_word", 32'(DATA_OUT), 32'h3C);
    drain();

    // Reset mid-word with two words queued
    DATA_READY = 1'b0;
    send_word(8'h11, 1'b1);
    send_word(8'h22, 1'b1);
    for (int i = 0; i < 5; i++) begin
      send_bit(1'b1, 1'b0);
      idle(2);
    end
    XRST = 1'b0;
    idle(1);
    XRST = 1'b1;
    chk("xrst_valid", 32'(DATA_VALID), 32'h0);
    chk("xrst_overrun", 32'(OVERRUN), 32'h0);
    send_word(8'hA7, 1'b1);
    chk("xrst_word", 32'(DATA_OUT), 32'hA7);
    drain();

    // Full FIFO, READY high on the strobe of the completing bit
    DATA_READY = 1'b0;
    for (int i = 0; i < 4; i++) send_word(W'(8'h40 + i), 1'b1);
    v = 8'h9D;
    for (int i = W - 1; i > 0; i--) begin
      send_bit(v[i], 1'b0);
      idle(2);
    end
    COMP_CLK = 1'b1;
    DIGITAL_OUT = v[0];
    idle(3);
    COMP_CLK = 1'b0;
    DATA_READY = 1'b1;
    cycle();
    DATA_READY = 1'b0;
    chk("full_pp_ovr", 32'(OVERRUN), 32'h0);
    chk("full_pp_head", 32'(DATA_OUT), 32'h41);
    idle(2);
    DATA_READY = 1'b1;
    chk("full_pp_d0", 32'(DATA_OUT), 32'h41);
    idle(1);
    chk("full_pp_d1", 32'(DATA_OUT), 32'h42);
    idle(1);
    chk("full_pp_d2", 32'(DATA_OUT), 32'h43);
    idle(1);
    chk("full_pp_d3", 32'(DATA_OUT), 32'h9D);
    idle(1);
    chk("full_pp_empty", 32'(DATA_VALID), 32'h0);

    // Randomized words, READY, occasional SYNC and OVR_CLR
    rnd_ready = 1'b1;
    for (int n = 0; n < 24; n++) begin
      v = W'($urandom);
      for (int i = W - 1; i >= 0; i--) begin
        send_bit(v[i], ($urandom_range(0, 31) == 0));
        OVR_CLR = ($urandom_range(0, 15) == 0);
        cycle();
        OVR_CLR = 1'b0;
        idle(1);
      end
    end
    rnd_ready = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
